// File: rtl/enc4x2_req.sv
// Registered 4-to-2 priority request encoder with a valid/ack handshake.
// Sticky pending bits are served one at a time, and each code is held until it is acknowledged.
module enc4x2_req #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Enable,
    input  logic [3:0] Z,
    input  logic       Ack,
    output logic       A,
    output logic       B,
    output logic       Valid,
    output logic       Multi
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_pend;
    logic [1:0] r_code;
    logic       r_valid;
    logic       r_multi;

    logic       w_handshake;
    logic [3:0] w_clr;
    logic [3:0] w_pendNext;
    logic [3:0] w_pendLessOne;
    logic [1:0] w_winner;
    logic       w_multi;

    // A bit that is re-raised in the same cycle it is cleared stays set, because the OR is applied after the clear.
    always_comb begin
        w_handshake = (r_state == ST_HOLD) && Ack;
        w_clr       = 4'b0000;
        if (w_handshake) begin
            w_clr[r_code] = 1'b1;
        end
        w_pendNext = (r_pend & ~w_clr) | (Z & {4{Enable}});
    end

    always_comb begin
        w_winner = 2'd0;
        if (HIGH_FIRST) begin
            casez (r_pend)
                4'b1???: w_winner = 2'd3;
                4'b01??: w_winner = 2'd2;
                4'b001?: w_winner = 2'd1;
                default: w_winner = 2'd0;
            endcase
        end else begin
            casez (r_pend)
                4'b???1: w_winner = 2'd0;
                4'b??10: w_winner = 2'd1;
                4'b?100: w_winner = 2'd2;
                4'b1000: w_winner = 2'd3;
                default: w_winner = 2'd0;
            endcase
        end
        // Clearing the lowest set bit leaves a nonzero value exactly when two or more bits are set.
        w_pendLessOne = r_pend - 4'd1;
        w_multi       = (r_pend & w_pendLessOne) != 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 4'b0000;
        end else begin
            r_pend <= w_pendNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_code  <= 2'd0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pend != 4'b0000) begin
                        r_code  <= w_winner;
                        r_multi <= w_multi;
                        r_valid <= 1'b1;
                        r_state <= ST_HOLD;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (Ack) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign A     = r_code[1];
    assign B     = r_code[0];
    assign Valid = r_valid;
    assign Multi = r_multi;

endmodule

// File: tb/tb_enc4x2_req.sv
// Bench for enc4x2_req: one instance of each priority order shares the same stimulus.
// A queue-free behavioural model tracks each instance, with hand-computed checkpoints.
module tb_enc4x2_req;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] z;
    logic       ack;
    logic [1:0] outA;
    logic [1:0] outB;
    logic [1:0] outValid;
    logic [1:0] outMulti;

    int checksTotal;
    int checksPassed;
    bit checkEn;

    // Behavioural model state; index 0 models HIGH_FIRST=1, index 1 models HIGH_FIRST=0.
    bit [3:0] mPend  [2];
    bit       mValid [2];
    bit [1:0] mCode  [2];
    bit       mMulti [2];

    enc4x2_req #(.HIGH_FIRST(1'b1)) dutHigh (
        .clk(clk), .rst(rst), .Enable(enable), .Z(z), .Ack(ack),
        .A(outA[0]), .B(outB[0]), .Valid(outValid[0]), .Multi(outMulti[0])
    );

    enc4x2_req #(.HIGH_FIRST(1'b0)) dutLow (
        .clk(clk), .rst(rst), .Enable(enable), .Z(z), .Ack(ack),
        .A(outA[1]), .B(outB[1]), .Valid(outValid[1]), .Multi(outMulti[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The model picks the winner by scanning the pending lines in priority order and counting how many are set.
    always @(posedge clk or posedge rst) begin
        bit [3:0] nextPend;
        int       count;
        int       pick;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mPend[d]  = 4'b0000;
                mValid[d] = 1'b0;
                mCode[d]  = 2'd0;
                mMulti[d] = 1'b0;
            end else begin
                nextPend = mPend[d];
                if (mValid[d] && ack) nextPend[mCode[d]] = 1'b0;
                if (enable) nextPend = nextPend | z;
                if (mValid[d]) begin
                    if (ack) mValid[d] = 1'b0;
                end else if (mPend[d] != 4'b0000) begin
                    count = 0;
                    pick  = -1;
                    for (int k = 0; k < 4; k++) begin
                        int line;
                        line = (d == 0) ? 3 - k : k;
                        if (mPend[d][line]) begin
                            count++;
                            if (pick < 0) pick = line;
                        end
                    end
                    mValid[d] = 1'b1;
                    mCode[d]  = 2'(pick);
                    mMulti[d] = (count > 1);
                end
                mPend[d] = nextPend;
            end
        end
    end

    task automatic checkField(input string name, input int d, input int act, input int exp);
        checksTotal++;
        if (act == exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int d = 0; d < 2; d++) begin
                checkField("model.Valid", d, int'(outValid[d]), int'(mValid[d]));
                checkField("model.Code", d, int'({outA[d], outB[d]}), int'(mCode[d]));
                checkField("model.Multi", d, int'(outMulti[d]), int'(mMulti[d]));
            end
        end
    end

    task automatic applyStimulus(input bit en, input bit [3:0] zIn, input bit ackIn);
        enable = en;
        z      = zIn;
        ack    = ackIn;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int d, input bit expValid,
                               input bit [1:0] expCode, input bit expMulti);
        checkField({name, ".Valid"}, d, int'(outValid[d]), int'(expValid));
        if (expValid) begin
            checkField({name, ".Code"}, d, int'({outA[d], outB[d]}), int'(expCode));
            checkField({name, ".Multi"}, d, int'(outMulti[d]), int'(expMulti));
        end
    endtask

    task automatic checkBoth(input string name, input bit expValid, input bit [1:0] expCode, input bit expMulti);
        checkOutput(name, 0, expValid, expCode, expMulti);
        checkOutput(name, 1, expValid, expCode, expMulti);
    endtask

    task automatic checkCleared(input string name);
        for (int d = 0; d < 2; d++) begin
            checkField({name, ".Valid"}, d, int'(outValid[d]), 0);
            checkField({name, ".Code"}, d, int'({outA[d], outB[d]}), 0);
            checkField({name, ".Multi"}, d, int'(outMulti[d]), 0);
        end
    endtask

    initial begin
        checksTotal  = 0;
        checksPassed = 0;
        checkEn      = 1'b0;
        rst          = 1'b1;
        enable       = 1'b0;
        z            = 4'b0000;
        ack          = 1'b0;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        checkEn = 1'b1;
        checkCleared("reset");

        // Single request: two edges from pulse to Valid, then one Ack retires it for good.
        applyStimulus(1'b1, 4'b0100, 1'b0);
        checkBoth("single.wait", 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("single.present", 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("single.ack", 1'b0, 2'd0, 1'b0);
        repeat (3) applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("single.quiet", 1'b0, 2'd0, 1'b0);

        // Priority order differs between the two instances.
        applyStimulus(1'b1, 4'b1011, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("prio.first", 0, 1'b1, 2'd3, 1'b1);
        checkOutput("prio.first", 1, 1'b1, 2'd0, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("prio.second", 0, 1'b1, 2'd1, 1'b1);
        checkOutput("prio.second", 1, 1'b1, 2'd1, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("prio.third", 0, 1'b1, 2'd0, 1'b0);
        checkOutput("prio.third", 1, 1'b1, 2'd3, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("prio.drained", 1'b0, 2'd0, 1'b0);

        // Hold stability: a later request on line 3 must not disturb the held code.
        applyStimulus(1'b1, 4'b0010, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("hold.present", 1'b1, 2'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0);
            checkBoth("hold.frozen", 1'b1, 2'd1, 1'b0);
        end
        applyStimulus(1'b1, 4'b0000, 1'b1);
        checkBoth("hold.ack", 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("hold.next", 1'b1, 2'd3, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkBoth("hold.ackDisabled", 1'b0, 2'd0, 1'b0);

        // Enable gating, plus a stray Ack while idle.
        applyStimulus(1'b0, 4'b1111, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkBoth("gate.blocked", 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0010, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("gate.open", 1'b1, 2'd1, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("gate.only", 1'b0, 2'd0, 1'b0);

        // Re-raise on the line being cleared survives the handshake.
        applyStimulus(1'b1, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("reraise.present", 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b1);
        checkBoth("reraise.gap", 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkBoth("reraise.again", 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1);
        applyStimulus(1'b1, 4'b0000, 1'b0);

        // Reset in the middle of a HOLD drops the code and every pending bit.
        applyStimulus(1'b1, 4'b1010, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b0);
        checkOutput("rstHold.present", 0, 1'b1, 2'd3, 1'b1);
        checkOutput("rstHold.present", 1, 1'b1, 2'd1, 1'b1);
        #2 rst = 1'b1;
        #1 checkCleared("rstHold.async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b0000, 1'b0);
            checkBoth("rstHold.after", 1'b0, 2'd0, 1'b0);
        end

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/enc4x2_req.md
# enc4x2_req

Registered 4-to-2 request encoder with valid/ack handshake; the inverse of the team's 2-to-4 decoder. It latches activity on four request lines Z[3:0] and presents the index of the highest-priority pending line as a 2-bit code {A,B}. The code is held stable until the consumer acknowledges it. Each served request is then cleared. The block sits between raw request/strobe lines and any logic that wants a binary line number, typically a dec2x4 driving the grant side.

## Interface
Parameters:
- HIGH_FIRST, default 1: 1 = Z[3] has the highest priority; 0 = Z[0] has the highest priority.

Ports:
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous, active-high reset
- Enable  input  1  capture enable for new requests; does not abort a transaction already presented
- Z  input  4  request lines, level-sampled every clock
- Ack  input  1  consumer accepts the presented code
- A  output  1  MSB of the encoded index
- B  output  1  LSB of the encoded index; index = {A,B}, matching dec2x4 (Z[{A,B}])
- Valid  output  1  {A,B} holds a pending request
- Multi  output  1  more than one request was pending when the current code was selected

## Operation
- Pending register pend[3:0], next value: pend_n = (pend & ~clr) | (Z & {4{Enable}}).
  - clr is one-hot on the presented index in the cycle a handshake completes; otherwise 0.
  - A re-raise on the bit being cleared in the same cycle wins: the bit stays set.
- FSM has two states, IDLE and HOLD.
  - IDLE: if pend != 0, select the priority winner of the registered pend, load {A,B} with it, set Valid=1, set Multi = (popcount(pend) > 1), and go to HOLD. If pend == 0, Valid=0 and the state stays IDLE.
  - HOLD: A, B, Valid and Multi are frozen. If Ack=1, this is a handshake: clear pend[{A,B}], set Valid=0, and go to IDLE. If Ack=0, stay in HOLD.
- Ack when Valid=0 is ignored and has no side effects.
- Enable=0 blocks new captures only. Already-pending bits are still served, and a HOLD still completes on Ack.
- Requests are sticky. A 1-cycle pulse on Z with Enable=1 is never lost, and is served exactly once per set/clear cycle.
- Repeated pulses on a bit that is already pending merge into one request.
- Outputs are driven only from registers; there is no combinational path from Z or Ack to any output.

## Timing
- Reset (async assert, any time) sets pend=0, state=IDLE, A=0, B=0, Valid=0, Multi=0. Deassertion is synchronous to clk, and the first capture happens on the first rising edge after rst falls.
- Reset during HOLD drops the presented code and all pending requests immediately, with no Ack needed.
- Latency: Z[i] sampled high at edge k sets pend[i] after edge k. If the FSM is in IDLE, Valid=1 with {A,B}=i after edge k+1, i.e. 2 edges from request to Valid.
- Handshake: Ack sampled high at edge m while in HOLD gives Valid=0 after edge m. The next code can present after edge m+1 at the earliest.
- Throughput is at most one code per 2 cycles.
- A higher-priority request arriving during HOLD does not preempt the held code. It is served on the next IDLE cycle.
- {A,B} and Multi keep their last value while Valid=0. Consumers must qualify them with Valid.

## Test plan
- Reset: assert rst mid-HOLD with pend=4'b1010 -> A=0, B=0, Valid=0, Multi=0 immediately. After release, Valid stays 0 with Z=0.
- Single request: Enable=1, pulse Z=4'b0100 for 1 cycle -> Valid=1, {A,B}=2'b10, Multi=0 after 2 edges. Ack for 1 cycle -> Valid=0 next edge and never reasserts.
- Priority (HIGH_FIRST=1): pulse Z=4'b1011 -> codes 11 (Multi=1), then 01 (Multi=1), then 00 (Multi=0), one per Ack. Repeat with HIGH_FIRST=0 -> order 00, 01, 11.
- Hold stability: present code 01, keep Ack=0 for 5 cycles while pulsing Z=4'b1000 -> {A,B}=01 and Valid stay frozen. After Ack, next code is 11.
- Enable gating: Enable=0, pulse Z=4'b1111 -> Valid stays 0. Enable=1 with Z=4'b0010 while pend=0 -> only code 01 is produced.
- Simultaneous clear and set: in HOLD with code 10, assert Ack and Z=4'b0100 on the same edge -> Valid=0 for 1 cycle, then Valid=1 with code 10 again.
